// File: rtl/donut_plotter.sv
// Bins renderer pixel samples into an 80x45 character-cell grid, keeping the per-cell
// maximum luminance for the current frame; a clear FSM wipes the buffer on reset/frame start.
module donut_plotter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 45,
  parameter int CELL_W = 24,
  parameter int CELL_H = 25,
  parameter int X_MAX  = 1920,
  parameter int Y_MAX  = 1125
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic        pix_valid_i,
  input  logic [10:0] pix_x_i,
  input  logic [10:0] pix_y_i,
  input  logic [3:0]  pix_lum_i,
  input  logic        frame_start_i,
  output logic        busy_o,
  input  logic [11:0] rd_addr_i,
  output logic [4:0]  rd_data_o,
  output logic [15:0] plot_cnt_o,
  output logic [15:0] drop_cnt_o
);

  localparam int          NCELL     = COLS * ROWS;
  localparam logic [11:0] NCELL_A   = 12'(NCELL);
  localparam logic [11:0] LAST_ADDR = 12'(NCELL - 1);
  localparam logic [10:0] XLIM      = 11'(X_MAX);
  localparam logic [10:0] YLIM      = 11'(Y_MAX);
  localparam logic [10:0] CW        = 11'(CELL_W);
  localparam logic [10:0] CH        = 11'(CELL_H);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic lum_wins(input logic [4:0] stored, input logic [3:0] lum);
    return !stored[4] || (lum > stored[3:0]);
  endfunction

  logic [4:0]  r_mem [0:NCELL-1];

  logic [0:0]  r_state;
  logic [11:0] r_clr_addr;
  logic [15:0] r_plot_cnt;
  logic [15:0] r_drop_cnt;
  logic        r_vld_p1, r_vld_p2, r_fwd_vld;
  logic [11:0] r_addr_p1, r_addr_p2, r_fwd_addr;
  logic [3:0]  r_lum_p1, r_lum_p2;
  logic [4:0]  r_rd_p2, r_fwd_data;
  logic [4:0]  r_rd_data;

  logic [10:0] w_col, w_row;
  logic [11:0] w_addr_p0;
  logic        w_acc, w_inr;
  logic [4:0]  w_old_p2;
  logic        w_pix_we, w_clr_we, w_we;
  logic [11:0] w_waddr;
  logic [4:0]  w_wdata;

  // P0: acceptance and cell binning
  assign w_acc     = cen_i & pix_valid_i & (r_state == ST_ACCUM) & ~frame_start_i;
  assign w_inr     = (pix_x_i < XLIM) && (pix_y_i < YLIM);
  assign w_col     = pix_x_i / CW;
  assign w_row     = pix_y_i / CH;
  assign w_addr_p0 = 12'(w_col) + 12'(w_row) * 12'(COLS);

  // P2: the previous write is not yet visible in r_rd_p2 when both hit the same cell
  assign w_old_p2 = (r_fwd_vld && (r_fwd_addr == r_addr_p2)) ? r_fwd_data : r_rd_p2;
  assign w_pix_we = cen_i & ~frame_start_i & r_vld_p2 & lum_wins(w_old_p2, r_lum_p2);
  assign w_clr_we = cen_i & (r_state == ST_CLEAR);
  assign w_we     = w_clr_we | w_pix_we;
  assign w_waddr  = w_clr_we ? r_clr_addr : r_addr_p2;
  assign w_wdata  = w_clr_we ? 5'd0 : {1'b1, r_lum_p2};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_fwd_vld  <= 1'b0;
      r_plot_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (cen_i) begin
      if (frame_start_i) begin
        r_state    <= ST_CLEAR;
        r_clr_addr <= '0;
        r_vld_p1   <= 1'b0;
        r_vld_p2   <= 1'b0;
        r_fwd_vld  <= 1'b0;
        r_plot_cnt <= '0;
        r_drop_cnt <= '0;
      end else begin
        r_vld_p1  <= w_acc & w_inr;
        r_vld_p2  <= r_vld_p1;
        r_fwd_vld <= w_pix_we;
        if (w_acc) begin
          if (w_inr) r_plot_cnt <= sat_inc(r_plot_cnt);
          else       r_drop_cnt <= sat_inc(r_drop_cnt);
        end
        if (r_state == ST_CLEAR) begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state    <= ST_ACCUM;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 12'd1;
          end
        end
      end
    end
  end

  // P1 -> P2: RMW read and data staging; buffer write
  always_ff @(posedge clk_i) begin
    if (cen_i) begin
      if (w_acc & w_inr) begin
        r_addr_p1 <= w_addr_p0;
        r_lum_p1  <= pix_lum_i;
      end
      r_addr_p2  <= r_addr_p1;
      r_lum_p2   <= r_lum_p1;
      r_rd_p2    <= r_mem[r_addr_p1];
      r_fwd_addr <= r_addr_p2;
      r_fwd_data <= {1'b1, r_lum_p2};
      if (w_we) r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_rd_data <= '0;
    else       r_rd_data <= (rd_addr_i < NCELL_A) ? r_mem[rd_addr_i] : 5'd0;
  end

  assign busy_o     = (r_state == ST_CLEAR);
  assign rd_data_o  = r_rd_data;
  assign plot_cnt_o = r_plot_cnt;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_donut_plotter.sv
// Scoreboarded bench for donut_plotter: a per-cell max-luminance model predicts scanout
// reads and counters; a negedge monitor pops expectations and compares.
`timescale 1ns/1ps
module tb_donut_plotter;

  logic        clk = 1'b0;
  logic        rst, cen, pv, fs;
  logic [10:0] px, py;
  logic [3:0]  pl;
  logic        busy;
  logic [11:0] ra;
  logic [4:0]  rd;
  logic [15:0] pc, dc;

  always #5 clk = ~clk;

  donut_plotter dut (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .pix_valid_i(pv),
    .pix_x_i(px), .pix_y_i(py), .pix_lum_i(pl), .frame_start_i(fs),
    .busy_o(busy), .rd_addr_i(ra), .rd_data_o(rd),
    .plot_cnt_o(pc), .drop_cnt_o(dc)
  );

  int total = 0;
  int bad   = 0;

  // kind 0 plot_cnt, 1 drop_cnt, 2 busy, 3 bench-measured value, 4 rd_data_o now
  typedef struct { string name; int kind; int act; int exp; } chk_t;
  typedef struct { int addr; int exp; } rd_t;
  chk_t sq[$];
  rd_t  rq[$];
  logic rd_req = 1'b0;
  logic rdv    = 1'b0;

  always @(posedge clk) rdv <= rd_req;

  always @(negedge clk) begin : monitor
    int   a;
    chk_t c;
    rd_t  r;
    while (sq.size() > 0) begin
      c = sq.pop_front();
      case (c.kind)
        0:       a = int'(pc);
        1:       a = int'(dc);
        2:       a = int'(busy);
        4:       a = int'(rd);
        default: a = c.act;
      endcase
      total++;
      if (a != c.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", c.name, a, c.exp);
      end
    end
    if (rdv) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got 0x%0h with no expected entry", rd);
      end else begin
        r = rq.pop_front();
        if (int'(rd) != r.exp) begin
          bad++;
          $display("FAIL rd[%0d]: got 0x%0h expected 0x%0h", r.addr, rd, r.exp);
        end
      end
    end
  end

  // Reference model: per-cell max with occupied flag, counters per frame
  logic [4:0] mdl [0:3599];
  int mplot, mdrop;

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3600; i++) mdl[i] = 5'd0;
    mplot = 0;
    mdrop = 0;
  endtask

  task automatic model_accept(input int x, input int y, input int l);
    int a;
    if (x < 1920 && y < 1125) begin
      mplot = sat(mplot);
      a = x / 24 + (y / 25) * 80;
      if (!mdl[a][4] || l > int'(mdl[a][3:0])) mdl[a] = {1'b1, 4'(l)};
    end else begin
      mdrop = sat(mdrop);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pv = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_pix(input int x, input int y, input int l);
    pv = 1'b1; px = 11'(x); py = 11'(y); pl = 4'(l);
    if (cen) model_accept(x, y, l);
    tick();
    pv = 1'b0;
  endtask

  task automatic chk_status(input string s, input int busy_exp);
    sq.push_back('{{s, "_plot"}, 0, 0, mplot});
    sq.push_back('{{s, "_drop"}, 1, 0, mdrop});
    sq.push_back('{{s, "_busy"}, 2, 0, busy_exp});
  endtask

  task automatic chk_val(input string s, input int act, input int exp);
    sq.push_back('{s, 3, act, exp});
  endtask

  task automatic read_raw(input int a, input int exp);
    rd_req = 1'b1;
    ra = 12'(a);
    rq.push_back('{a, exp});
    tick();
  endtask

  task automatic read_cell(input int a);
    read_raw(a, (a < 3600) ? int'(mdl[a]) : 0);
  endtask

  task automatic read_end();
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_all();
    for (int a = 0; a < 3600; a++) read_cell(a);
    read_cell(3600);
    read_cell(4095);
    read_end();
  endtask

  // Waits out a clear, optionally offering pixels that must be ignored
  task automatic wait_clear(input bit junk, input string s);
    int cnt = 0;
    while (busy && cnt < 5000) begin
      if (junk) begin
        pv = 1'b1;
        px = 11'($urandom_range(0, 1919));
        py = 11'($urandom_range(0, 1124));
        pl = 4'($urandom_range(0, 15));
      end
      tick();
      cnt++;
    end
    pv = 1'b0;
    chk_val(s, cnt, 3600);
  endtask

  task automatic frame_restart(input bit junk, input string s);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    model_clear();
    wait_clear(junk, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cen = 1'b1; pv = 1'b0; fs = 1'b0;
    px = '0; py = '0; pl = '0; ra = '0;
    model_clear();
    tick();
    tick();
    chk_status("in_reset", 1);
    sq.push_back('{"in_reset_rd", 4, 0, 0});
    tick();
    rst = 1'b0;

    // Reset clear
    wait_clear(1'b0, "reset_busy_len");
    chk_status("after_reset", 0);
    tick();
    tick();
    read_all();

    // Single pixel, exact commit timing
    drive_pix(100, 50, 7);
    chk_status("single", 0);
    read_raw(164, 0);
    read_raw(164, 0);
    read_raw(164, 5'h17);
    read_end();
    read_all();

    // Same-cell back-to-back
    drive_pix(30, 30, 3);
    drive_pix(31, 32, 9);
    drive_pix(40, 40, 5);
    idle(3);
    read_raw(81, 5'h19);
    read_cell(80);
    read_cell(82);
    read_cell(164);
    read_end();
    chk_status("same_cell", 0);

    // Out-of-range, with junk pixels offered during the clear
    frame_restart(1'b1, "clr_junk_len");
    chk_status("after_junk_clear", 0);
    drive_pix(1920, 10, 5);
    drive_pix(10, 1125, 5);
    idle(3);
    chk_status("oor", 0);
    read_cell(80);
    read_cell(0);
    read_cell(3599);
    read_cell(3520);
    read_end();
    drive_pix(1919, 1124, 2);
    idle(3);
    read_raw(3599, 5'h12);
    read_end();
    chk_status("corner", 0);

    // Frame start one cycle after acceptance, with a competing pixel
    frame_restart(1'b0, "clr2_len");
    drive_pix(500, 500, 8);
    fs = 1'b1; pv = 1'b1; px = 11'd600; py = 11'd600; pl = 4'd9;
    tick();
    fs = 1'b0; pv = 1'b0;
    model_clear();
    chk_status("fs_squash", 1);
    wait_clear(1'b0, "fs_mid_len");
    chk_status("fs_after", 0);
    read_all();

    // Stall between acceptance and commit
    drive_pix(200, 300, 11);
    cen = 1'b0;
    pv = 1'b1; px = 11'd201; py = 11'd301; pl = 4'd15;
    for (int i = 0; i < 10; i++) read_raw(968, 0);
    chk_status("stall", 0);
    cen = 1'b1; pv = 1'b0;
    read_raw(968, 0);
    read_raw(968, 0);
    read_raw(968, 5'h1B);
    read_end();
    chk_status("post_stall", 0);

    // Randomized traffic with clustering for hazards and random cen
    frame_restart(1'b1, "clr3_len");
    for (int i = 0; i < 800; i++) begin
      int sel, x, y, l;
      cen = ($urandom_range(0, 4) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        x = $urandom_range(0, 71);
        y = $urandom_range(0, 74);
      end else if (sel == 7) begin
        x = $urandom_range(1900, 2047);
        y = $urandom_range(1100, 2047);
      end else begin
        x = $urandom_range(0, 1919);
        y = $urandom_range(0, 1124);
      end
      l = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) drive_pix(x, y, l);
      else idle(1);
    end
    cen = 1'b1;
    idle(3);
    chk_status("random", 0);
    read_all();

    // Mid-operation reset
    drive_pix(48, 50, 6);
    drive_pix(49, 51, 12);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk_status("mid_reset", 1);
    sq.push_back('{"mid_reset_rd", 4, 0, 0});
    tick();
    rst = 1'b0;
    wait_clear(1'b0, "rst2_len");
    chk_status("after_rst2", 0);
    read_cell(162);
    read_cell(0);
    read_end();

    idle(2);
    chk_val("rq_drained", rq.size(), 0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/donut_plotter.md
# donut_plotter

Consumer end of the donut renderer's pixel stream. Accepts `xp`/`yp`/`lum`/`valid` samples and bins each 1920x1125 screen coordinate into a character-cell grid. The grid is 80x45 cells of 24x25 px. Each cell keeps the maximum luminance plotted into it during the current frame, held in an on-chip cell buffer. A clear state machine wipes the buffer at reset and on every frame start. An independent read port serves the display/ASCII scanout logic.

## Interface
Parameters:
- `COLS`, 80, cell columns
- `ROWS`, 45, cell rows
- `CELL_W`, 24, pixels per cell horizontally
- `CELL_H`, 25, pixels per cell vertically
- `X_MAX`, 1920, first out-of-range X
- `Y_MAX`, 1125, first out-of-range Y

Ports:
- `clk_i`  in  1  sole clock
- `rst_i`  in  1  asynchronous, active-high reset
- `cen_i`  in  1  clock enable for the plot pipeline, the clear FSM and the counters
- `pix_valid_i`  in  1  pixel sample valid (renderer `valid_o`)
- `pix_x_i`  in  11  screen X
- `pix_y_i`  in  11  screen Y
- `pix_lum_i`  in  4  luminance 0..15
- `frame_start_i`  in  1  single-cycle pulse, sampled when `cen_i`=1: start a new frame
- `busy_o`  out  1  clear in progress; pixels are ignored
- `rd_addr_i`  in  12  scanout cell address, `col + row*COLS`
- `rd_data_o`  out  5  `{occupied, lum[3:0]}` of the addressed cell
- `plot_cnt_o`  out  16  pixels accepted this frame, saturating
- `drop_cnt_o`  out  16  pixels rejected this frame, saturating

## Operation
- **Cell buffer:** `COLS*ROWS` (3600) x 5 bits.
  - One write port.
  - One synchronous read port for read-modify-write.
  - One synchronous scanout read port.
- **States:**
  - `CLEAR`: writes 0 to address `clr_addr`, which increments 0..3599, one write per `cen_i` cycle. After address 3599 the FSM moves to `ACCUM`. `busy_o`=1 throughout `CLEAR`.
  - `ACCUM`: plot pipeline active. `busy_o`=0.
- **Reset:** state=`CLEAR`, `clr_addr`=0, pipeline valids=0, both counters=0, `busy_o`=1, `rd_data_o`=0.
- **`frame_start_i` in any state:** enter `CLEAR` with `clr_addr`=0, zero both counters, and squash every in-flight pipeline stage. A pulse received during `CLEAR` restarts the clear from 0.
- **Stage P0 (acceptance):** a pixel is accepted when `pix_valid_i`=1, state=`ACCUM` and `cen_i`=1.
  - If `pix_x_i`≥`X_MAX` or `pix_y_i`≥`Y_MAX`, the pixel is dropped: `drop_cnt_o`++ and no write occurs.
  - Otherwise `plot_cnt_o`++ and the pixel advances with `col = x / CELL_W`, `row = y / CELL_H`.
  - Division is by constant; integer floor.
- **Stage P1:** register `addr = col + row*COLS` (12 bits) and `lum`; issue the RMW read.
- **Stage P2:** compare and write.
  - If the stored `occupied`=0 or `lum` > stored `lum`, write `{1, lum}`; otherwise write nothing.
  - A tie keeps the stored value.
- **Hazard:** if P2 of the previous accepted pixel wrote the same address, P2 uses the forwarded written value instead of the RAM read data. Back-to-back same-cell pixels must resolve to the maximum.
- **`pix_valid_i` in `CLEAR`:** ignored; neither counter changes.
- **Counters:** saturate at 0xFFFF.
- **Scanout port:** `rd_data_o` is registered every clock, independent of `cen_i` and state. A read of an address ≥3600 returns 0.

## Timing
- All pipeline registers, the FSM and the counters advance only on edges where `cen_i`=1. With `cen_i`=0, everything holds and no RAM write occurs.
- For a pixel accepted on cen-cycle N:
  - the RAM write commits at the edge ending cen-cycle N+2;
  - `rd_addr_i` presented in any clock after that edge returns the new value on the next clock.
- Counters update at the edge ending cycle N.
- **Clear duration:** exactly 3600 cen-cycles.
  - `busy_o` falls at the edge that writes address 3599.
  - A pixel presented in the following cen-cycle is accepted.
- **`frame_start_i` simultaneous with an accepted-looking pixel:** `frame_start_i` wins; the pixel is not counted.
- **Mid-operation reset:** all state is forced immediately to its reset values. Buffer contents are undefined until the clear completes.

## Test plan
- **Reset:** assert `rst_i`, then hold `cen_i`=1. Required: `busy_o`=1 for exactly 3600 cycles, then 0; reading every address 0..3599 returns 0.
- **Single pixel:** pixel (100,50,lum=7) after the clear. Required: address 164 (col 4, row 2) reads 5'b1_0111 one clock after the commit edge (N+2); `plot_cnt_o`=1; all other cells read 0.
- **Same-cell sequence:** consecutive pixels (30,30,3), (31,32,9), (40,40,5), all in cell 81. Required: final `rd_data_o` at 81 is 5'b1_1001, proving forwarding.
- **Out-of-range:** pixels (1920,10,5) and (10,1125,5). Required: `drop_cnt_o`=2, `plot_cnt_o`=0, no cell written; (1919,1124,2) writes cell 3599 to 5'b1_0010.
- **Mid-pipeline frame start:** pulse `frame_start_i` one cycle after accepting (500,500,8). Required: the squashed pixel never appears; after 3600 cycles all cells are 0 and both counters are 0.
- **Stall:** drop `cen_i` for 10 clocks between acceptance and commit. Required: no write during the stall; the commit happens on the 2nd cen-cycle after resumption; scanout reads keep working while stalled.
